// File: rtl/regfile_16x16_sb.sv
// Sixteen 16-bit registers with a write-back port and a per-register busy scoreboard gating issue.
// Optional: define REGFILE_R0_ZERO_EN to hardwire register 0 to zero.
module regfile_16x16_sb (
    input  logic         clk,
    input  logic         rst,
    input  logic         wb_en,
    input  logic [3:0]   wb_addr,
    input  logic [15:0]  wb_data,
    input  logic         iss_valid,
    input  logic [3:0]   iss_rd,
    input  logic [3:0]   iss_rs,
    input  logic [3:0]   iss_rt,
    output logic         iss_ready,
    output logic [3:0]   rs_sel,
    output logic [3:0]   rt_sel,
    output logic [255:0] q,
    output logic [15:0]  busy,
    output logic         wb_err
);
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wb_hit;
    logic              iss_acc;
    logic              busy_set;
    logic [15:0]       busy_nxt;

    // Index 0 is invisible to both ports when hardwired.
    assign wb_hit    = wb_en && !(R0_ZERO && (wb_addr == 4'd0));
    assign iss_ready = !(busy[iss_rs] | busy[iss_rt] | busy[iss_rd]);
    assign iss_acc   = iss_valid && iss_ready;
    assign busy_set  = iss_acc && !(R0_ZERO && (iss_rd == 4'd0));

    // Clear from write-back first, then set from issue, so a colliding set wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_hit)
            busy_nxt[wb_addr] = 1'b0;
        if (busy_set)
            busy_nxt[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++)
                regs[k] <= '0;
            busy   <= '0;
            rs_sel <= '0;
            rt_sel <= '0;
            wb_err <= 1'b0;
        end else begin
            if (wb_hit) begin
                regs[wb_addr] <= wb_data;
                if (!busy[wb_addr])
                    wb_err <= 1'b1;
            end
            if (iss_acc) begin
                rs_sel <= iss_rs;
                rt_sel <= iss_rt;
            end
            busy <= busy_nxt;
        end
    end

    always_comb begin
        q = '0;
        for (int k = 0; k < DEPTH; k++)
            q[DATA_W*k +: DATA_W] = regs[k];
`ifdef REGFILE_R0_ZERO_EN
        q[DATA_W-1:0] = '0;
`else
        q[DATA_W-1:0] = regs[0];
`endif
    end

endmodule

// File: doc/regfile_16x16_sb.md
# regfile_16x16_sb

Sixteen-entry, 16-bit register bank with a write-back port and a per-register busy scoreboard. It sits directly upstream of the 16-bit 16:1 read multiplexers. It drives all sixteen register values and registered read-select codes into those muxes. It stalls issue while a source or destination register has a write outstanding.

## Interface
Parameters: none (width 16 and depth 16 are fixed to match the downstream muxes).
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- wb_en  in  1  write-back strobe.
- wb_addr  in  4  write-back register index.
- wb_data  in  16  write-back data.
- iss_valid  in  1  issue request.
- iss_rd  in  4  destination register to mark busy.
- iss_rs  in  4  first source register.
- iss_rt  in  4  second source register.
- iss_ready  out  1  issue accepted this cycle when high together with iss_valid.
- rs_sel  out  4  registered select for mux A.
- rt_sel  out  4  registered select for mux B.
- q  out  256  register contents; q[16k+15:16k] = register k.
- busy  out  16  scoreboard; bit k set while register k awaits write-back.
- wb_err  out  1  sticky flag: write-back hit a non-busy register.

## Operation
- Reset (async, immediate) sets the outputs as follows: all registers = 16'h0000, busy = 16'h0000, rs_sel = rt_sel = 4'h0, wb_err = 0. A reset asserted mid-operation discards all pending state; there is no recovery of outstanding writes.
- Write-back: on a clk edge with wb_en = 1, register[wb_addr] ← wb_data, and busy[wb_addr] is cleared. If busy[wb_addr] was 0 at that edge, the data is still written and wb_err is set, staying set until rst.
- Hazard check (combinational): iss_ready = !(busy[iss_rs] | busy[iss_rt] | busy[iss_rd]). It uses the current busy vector only; there is no same-cycle bypass of a clearing write-back.
- Issue accept: on a clk edge with iss_valid & iss_ready, rs_sel ← iss_rs, rt_sel ← iss_rt, busy[iss_rd] ← 1. Otherwise rs_sel and rt_sel hold.
- Simultaneous write-back and accepted issue on the same index (possible only when the register is not busy, i.e. a wb_err case): the set wins, so busy stays 1 and the data is written.
- Per-register state: IDLE (busy = 0) → PENDING on accepted issue targeting it. PENDING → IDLE on write-back to it.
- iss_valid = 0 implies no state change from the issue side; iss_ready is still driven.

## Timing
- Write-back latency: wb_data is visible on q one cycle after the wb_en edge.
- Select latency: rs_sel and rt_sel update one cycle after acceptance. Downstream mux outputs are therefore valid in the cycle after issue.
- Busy latency: busy[rd] is visible one cycle after acceptance. iss_ready is combinational from busy and the iss_* inputs, within the same cycle.
- Minimum stall for a RAW dependency: an issue in the same cycle as the clearing write-back is refused. It is accepted at the earliest one cycle later.
- All outputs are registered except iss_ready.

## Configuration
- REGFILE_R0_ZERO_EN defined: register 0 is hardwired.
  - q[15:0] is always 16'h0000.
  - Write-back to index 0 is ignored and does not set wb_err.
  - busy[0] is never set, and index 0 never causes a stall.
- Not defined: register 0 behaves like all others.

## Test plan
- Reset release, then wb_en with addr 5 and data 16'hBEEF → next cycle q[95:80] = 16'hBEEF, all other fields 0, and wb_err = 1 because reg 5 was not busy.
- Issue rd=3, rs=1, rt=2 with busy = 0 → iss_ready = 1. Next cycle busy = 16'h0008, rs_sel = 1, rt_sel = 2.
- With busy[3] = 1, issue rs=3 → iss_ready = 0 and selects hold. Write-back to 3 in the same cycle → issue still refused. Next cycle it is accepted and busy[3] = 0.
- Write-back to 7 and accepted issue with rd=7 on the same edge (reg 7 not busy) → q[127:112] updated, busy[7] = 1, wb_err = 1.
- With REGFILE_R0_ZERO_EN: write-back to 0 with data 16'h1234 → q[15:0] = 0 and wb_err = 0. Issue rd=0 → busy stays 0.
- Assert rst while busy = 16'hFFFF and selects are nonzero → all outputs return to their reset values immediately, without a clock edge.
